fetch_stage: RTL

Instruction-fetch stage of the pipelined RV32I core: holds the program counter, drives the byte address into the asynchronous-read instruction ROM (mapped 0xBFC00000–0xBFC00FFF), and captures the returned word into the IF/ID pipeline register for decode. It implements the next-PC selection, hazard-unit stall, branch/jump flush, and a sticky fetch-fault flag for misaligned or out-of-window PCs.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 22 ++
 rtl/if_id_reg.sv | 16 +
 rtl/fetch_stage.sv | 43 ++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core constants, the IF/ID pipeline word, and the fetch-address fault check
package cpu_pkg;
  localparam logic [31:0] RESET_PC   = 32'hBFC00000;
  localparam logic [31:0] IMEM_BASE  = 32'hBFC00000;
  localparam logic [31:0] IMEM_BYTES = 32'd4096;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;
  localparam logic [31:0] IMEM_LAST  = IMEM_BASE + IMEM_BYTES - 32'd4;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;
  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};
  function automatic logic pc_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IMEM_BASE) || (pc > IMEM_LAST);
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch bus; master = hazard/EX/ROM side (drives instr_data, stall, flush, pc_src, pc_target), slave = fetch_stage (drives instr_addr and the IF/ID outputs)
interface fetch_stage_if;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        stall;
  logic        flush;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        fetch_fault;
  modport master (
    output instr_data, stall, flush, pc_src, pc_target,
    input  instr_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_fault
  );
  modport slave (
    input  instr_data, stall, flush, pc_src, pc_target,
    output instr_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_fault
  );
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; i_clr loads a bubble and beats i_en, i_en loads i_d, o_q is the held word
import cpu_pkg::*;
module if_id_reg (
  input  logic   clk,
  input  logic   i_en,
  input  logic   i_clr,
  input  if_id_t i_d,
  output if_id_t o_q
);
  if_id_t r_q;
  always_ff @(posedge clk) begin
    if (i_clr) r_q <= BUBBLE;
    else if (i_en) r_q <= i_d;
  end
  assign o_q = r_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC mux, fault check and IF/ID capture; clk/rst plain, everything else on fetch_stage_if.slave
import cpu_pkg::*;
module fetch_stage (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.slave  bus
);
  logic [31:0] r_pc;
  logic        r_fault;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_fault_cap;
  if_id_t      w_d;
  if_id_t      w_q;
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_fault_cap = ~bus.flush & ~bus.stall & pc_fault(r_pc);
  always_comb begin
    w_pc_next = bus.pc_src ? bus.pc_target : bus.stall ? r_pc : w_pc_plus4;
    w_d       = '{instr: bus.instr_data, pc: r_pc, pc_plus4: w_pc_plus4, valid: 1'b1};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_fault <= r_fault | w_fault_cap;
    end
  end
  if_id_reg u_if_id (
    .clk   (clk),
    .i_en  (~bus.stall),
    .i_clr (rst | bus.flush | w_fault_cap),
    .i_d   (w_d),
    .o_q   (w_q)
  );
  assign bus.instr_addr  = r_pc;
  assign bus.instr_d     = w_q.instr;
  assign bus.pc_d        = w_q.pc;
  assign bus.pc_plus4_d  = w_q.pc_plus4;
  assign bus.valid_d     = w_q.valid;
  assign bus.fetch_fault = r_fault;
endmodule
